// File: rtl/pipelined_udiv.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_udiv
// Description : Fully pipelined unsigned restoring divider. Divides a
//               2*D_WIDTH-bit dividend by a D_WIDTH-bit divisor, one
//               operation per enabled clock, result D_WIDTH enabled cycles
//               later with a valid bit travelling alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_udiv #(
    parameter int D_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ce,
    input  logic                   i_valid,
    input  logic [2*D_WIDTH-1:0]   i_z,
    input  logic [D_WIDTH-1:0]     i_d,
    output logic                   o_valid,
    output logic [D_WIDTH-1:0]     o_q,
    output logic [D_WIDTH-1:0]     o_s,
    output logic                   o_div0,
    output logic                   o_ovf
);

    localparam logic [D_WIDTH-1:0] c_all_ones = '1;

    // Stage registers. r_zq_q holds the not-yet-consumed dividend bits in its
    // upper part and the quotient bits resolved so far in its lower part;
    // after D_WIDTH shifts it is the complete quotient. The partial remainder
    // is always below the divisor, so D_WIDTH bits suffice between stages;
    // the trial value inside a stage is D_WIDTH+1 bits wide.
    logic [D_WIDTH-1:0] r_rem_q  [D_WIDTH];
    logic [D_WIDTH-1:0] r_zq_q   [D_WIDTH];
    logic [D_WIDTH-1:0] r_div_q  [D_WIDTH];
    logic               r_div0_q [D_WIDTH];
    logic               r_ovf_q  [D_WIDTH];
    logic               r_vld_q  [D_WIDTH];

    logic [D_WIDTH-1:0] w_rem_d  [D_WIDTH];
    logic [D_WIDTH-1:0] w_zq_d   [D_WIDTH];
    logic [D_WIDTH-1:0] w_div_d  [D_WIDTH];
    logic               w_div0_d [D_WIDTH];
    logic               w_ovf_d  [D_WIDTH];
    logic               w_vld_d  [D_WIDTH];

    // Per-stage operands: stage 0 takes the raw inputs, later stages take the
    // previous stage's registers.
    logic [D_WIDTH-1:0] w_rem_in  [D_WIDTH];
    logic [D_WIDTH-1:0] w_zq_in   [D_WIDTH];
    logic [D_WIDTH-1:0] w_div_in  [D_WIDTH];
    logic               w_div0_in [D_WIDTH];
    logic               w_ovf_in  [D_WIDTH];
    logic               w_vld_in  [D_WIDTH];

    // Route inputs to stage 0 and each stage's registers to the next stage.
    always_comb begin
        w_rem_in[0]  = i_z[2*D_WIDTH-1:D_WIDTH];
        w_zq_in[0]   = i_z[D_WIDTH-1:0];
        w_div_in[0]  = i_d;
        w_div0_in[0] = (i_d == '0);
        w_ovf_in[0]  = (i_z[2*D_WIDTH-1:D_WIDTH] >= i_d);
        w_vld_in[0]  = i_valid;
        for (int k = 1; k < D_WIDTH; k++) begin
            w_rem_in[k]  = r_rem_q[k-1];
            w_zq_in[k]   = r_zq_q[k-1];
            w_div_in[k]  = r_div_q[k-1];
            w_div0_in[k] = r_div0_q[k-1];
            w_ovf_in[k]  = r_ovf_q[k-1];
            w_vld_in[k]  = r_vld_q[k-1];
        end
    end

    // One restoring-subtraction step per stage; the last stage also applies
    // the saturated overflow result so the output registers hold final values.
    always_comb begin
        logic [D_WIDTH:0]   t;
        logic               ge;
        logic [D_WIDTH-1:0] rem_nx;
        logic [D_WIDTH-1:0] zq_nx;
        for (int k = 0; k < D_WIDTH; k++) begin
            t       = {w_rem_in[k], w_zq_in[k][D_WIDTH-1]};
            ge      = (t >= {1'b0, w_div_in[k]});
            rem_nx  = ge ? (t[D_WIDTH-1:0] - w_div_in[k]) : t[D_WIDTH-1:0];
            zq_nx   = w_zq_in[k] << 1;
            zq_nx[0] = ge;
            if ((k == D_WIDTH - 1) && w_ovf_in[k]) begin
                zq_nx  = c_all_ones;
                rem_nx = '0;
            end
            w_rem_d[k]  = rem_nx;
            w_zq_d[k]   = zq_nx;
            w_div_d[k]  = w_div_in[k];
            w_div0_d[k] = w_div0_in[k];
            w_ovf_d[k]  = w_ovf_in[k];
            w_vld_d[k]  = w_vld_in[k];
        end
    end

    // Pipeline registers: reset clears everything, i_ce=0 freezes all stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < D_WIDTH; k++) begin
                r_rem_q[k]  <= '0;
                r_zq_q[k]   <= '0;
                r_div_q[k]  <= '0;
                r_div0_q[k] <= 1'b0;
                r_ovf_q[k]  <= 1'b0;
                r_vld_q[k]  <= 1'b0;
            end
        end else if (i_ce) begin
            for (int k = 0; k < D_WIDTH; k++) begin
                r_rem_q[k]  <= w_rem_d[k];
                r_zq_q[k]   <= w_zq_d[k];
                r_div_q[k]  <= w_div_d[k];
                r_div0_q[k] <= w_div0_d[k];
                r_ovf_q[k]  <= w_ovf_d[k];
                r_vld_q[k]  <= w_vld_d[k];
            end
        end
    end

    assign o_valid = r_vld_q[D_WIDTH-1];
    assign o_q     = r_zq_q[D_WIDTH-1];
    assign o_s     = r_rem_q[D_WIDTH-1];
    assign o_div0  = r_div0_q[D_WIDTH-1];
    assign o_ovf   = r_ovf_q[D_WIDTH-1];

    // The divisor copy in the last stage has no consumer downstream.
    logic w_unused;
    assign w_unused = ^r_div_q[D_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_udiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_udiv
// Description : Directed, table-driven bench for pipelined_udiv (D_WIDTH=8)
//               plus one 16.16 fixed-point case at D_WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_udiv;

    logic        clk;
    logic        rst;
    logic        ce;

    logic        v8;
    logic [15:0] z8;
    logic [7:0]  d8;
    logic        ov8;
    logic [7:0]  q8;
    logic [7:0]  s8;
    logic        dz8;
    logic        of8;

    logic        v32;
    logic [63:0] z32;
    logic [31:0] d32;
    logic        ov32;
    logic [31:0] q32;
    logic [31:0] s32;
    logic        dz32;
    logic        of32;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] z;
        logic [7:0]  d;
        logic [7:0]  q;
        logic [7:0]  s;
        logic        div0;
        logic        ovf;
    } vec_t;

    vec_t vt[11];
    vec_t seq[5];
    logic seq_v[5];

    pipelined_udiv #(.D_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(v8), .i_z(z8), .i_d(d8),
        .o_valid(ov8), .o_q(q8), .o_s(s8), .o_div0(dz8), .o_ovf(of8)
    );

    pipelined_udiv #(.D_WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(v32), .i_z(z32), .i_d(d32),
        .o_valid(ov32), .o_q(q32), .o_s(s32), .o_div0(dz32), .o_ovf(of32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out8(input string tag, input vec_t v);
        chk({tag, " valid"}, {63'd0, ov8}, 64'd1);
        chk({tag, " q"},     {56'd0, q8},  {56'd0, v.q});
        chk({tag, " s"},     {56'd0, s8},  {56'd0, v.s});
        chk({tag, " div0"},  {63'd0, dz8}, {63'd0, v.div0});
        chk({tag, " ovf"},   {63'd0, of8}, {63'd0, v.ovf});
    endtask

    // Issue one op, expect a single o_valid pulse exactly 8 enabled edges later.
    task automatic run_vec(input string tag, input vec_t v);
        z8 = v.z; d8 = v.d; v8 = 1'b1;
        tick();
        v8 = 1'b0; z8 = '0; d8 = '0;
        for (int c = 1; c < 8; c++) begin
            if (ov8 !== 1'b0) chk({tag, " early valid"}, {63'd0, ov8}, 64'd0);
            tick();
        end
        chk_out8(tag, v);
        tick();
        chk({tag, " valid pulse end"}, {63'd0, ov8}, 64'd0);
    endtask

    initial begin
        vt[0]  = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
        vt[1]  = '{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0};
        vt[2]  = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{16'h00C8, 8'h0A, 8'h14, 8'h00, 1'b0, 1'b0};
        vt[4]  = '{16'h0005, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1};
        vt[5]  = '{16'h0800, 8'h08, 8'hFF, 8'h00, 1'b0, 1'b1};
        vt[6]  = '{16'h07FF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0};
        vt[7]  = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        vt[8]  = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0};
        vt[9]  = '{16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0};
        vt[10] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};

        seq[0] = vt[0]; seq_v[0] = 1'b1;
        seq[1] = vt[1]; seq_v[1] = 1'b1;
        seq[2] = vt[2]; seq_v[2] = 1'b1;
        seq[3] = '{16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}; seq_v[3] = 1'b0;
        seq[4] = vt[3]; seq_v[4] = 1'b1;

        rst = 1'b1; ce = 1'b1;
        v8 = 1'b0; z8 = '0; d8 = '0;
        v32 = 1'b0; z32 = '0; d32 = '0;
        tick();
        tick();
        chk("rst valid8", {63'd0, ov8}, 64'd0);
        chk("rst q8",     {56'd0, q8},  64'd0);
        chk("rst s8",     {56'd0, s8},  64'd0);
        chk("rst div0_8", {63'd0, dz8}, 64'd0);
        chk("rst ovf8",   {63'd0, of8}, 64'd0);
        chk("rst valid32", {63'd0, ov32}, 64'd0);
        chk("rst q32",     {32'd0, q32},  64'd0);
        chk("rst s32",     {32'd0, s32},  64'd0);
        rst = 1'b0;
        tick();

        // Single-op vectors, each checked for latency and values.
        for (int i = 0; i < 11; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i]);
        end

        // 16.16 fixed point 0.5/1.0 at D_WIDTH=32.
        z32 = 64'h0000_0000_8000_0000; d32 = 32'h0001_0000; v32 = 1'b1;
        tick();
        v32 = 1'b0; z32 = '0; d32 = '0;
        for (int c = 1; c < 32; c++) begin
            if (ov32 !== 1'b0) chk("w32 early valid", {63'd0, ov32}, 64'd0);
            tick();
        end
        chk("w32 valid", {63'd0, ov32}, 64'd1);
        chk("w32 q",     {32'd0, q32},  64'h8000);
        chk("w32 s",     {32'd0, s32},  64'd0);
        chk("w32 ovf",   {63'd0, of32}, 64'd0);

        // Back-to-back with a bubble: results in order at fixed latency.
        for (int c = 0; c <= 12; c++) begin
            if (c >= 8) begin
                if (seq_v[c-8]) chk_out8($sformatf("b2b slot%0d", c-8), seq[c-8]);
                else chk("b2b bubble valid", {63'd0, ov8}, 64'd0);
            end else if (ov8 !== 1'b0) begin
                chk("b2b early valid", {63'd0, ov8}, 64'd0);
            end
            if (c < 5) begin
                v8 = seq_v[c]; z8 = seq[c].z; d8 = seq[c].d;
            end else begin
                v8 = 1'b0; z8 = '0; d8 = '0;
            end
            tick();
        end

        // Stall mid-flight for 5 cycles, then a stall spanning the output cycle.
        z8 = 16'h0064; d8 = 8'h07; v8 = 1'b1;
        tick();
        v8 = 1'b0; z8 = '0; d8 = '0;
        tick();
        tick();
        ce = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall hold valid", {63'd0, ov8}, 64'd0);
        end
        ce = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("stall pre valid", {63'd0, ov8}, 64'd0);
        end
        tick();
        chk_out8("stall result", vt[0]);
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out8("stall output hold", vt[0]);
        end
        ce = 1'b1;
        tick();
        chk("stall release valid", {63'd0, ov8}, 64'd0);

        // Reset with four ops in flight.
        for (int i = 0; i < 4; i++) begin
            v8 = 1'b1; z8 = vt[i].z; d8 = vt[i].d;
            tick();
        end
        v8 = 1'b0; z8 = '0; d8 = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst valid", {63'd0, ov8}, 64'd0);
        chk("mid rst q",     {56'd0, q8},  64'd0);
        chk("mid rst s",     {56'd0, s8},  64'd0);
        chk("mid rst div0",  {63'd0, dz8}, 64'd0);
        chk("mid rst ovf",   {63'd0, of8}, 64'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("post rst no valid", {63'd0, ov8}, 64'd0);
        end
        run_vec("post rst op", vt[9]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
